// File: rtl/wqe_segmenter_pkg.sv
// Shared WQE field layout and segmenter FSM encodings, also used by the WQE cache.
package wqe_segmenter_pkg;

  localparam int WQE_WRID_LSB = 0;
  localparam int WQE_WRID_W   = 64;
  localparam int WQE_LEN_LSB  = 64;
  localparam int WQE_LEN_W    = 32;
  localparam int WQE_ADDR_LSB = 128;
  localparam int WQE_ADDR_W   = 64;
  localparam int WQE_QPID_LSB = 328;

  typedef enum logic [1:0] {
    SEG_IDLE = 2'd0,
    SEG_WAIT = 2'd1,
    SEG_SEG  = 2'd2
  } seg_state_e;

  // Segment payload size in bytes, one bit wider than any 32-bit WQE length.
  function automatic logic [WQE_LEN_W:0] mtu_bytes(input int mtu_log2);
    return (WQE_LEN_W+1)'(1) << mtu_log2;
  endfunction

endpackage

// File: rtl/wqe_segmenter_seg_calc.sv
// Combinational segment math: current segment length, last flag and the
// address/remaining pair that the next segment starts from.
module seg_calc
  import wqe_segmenter_pkg::*;
#(
  parameter int MTU_LOG2 = 12
) (
  input  logic [WQE_ADDR_W-1:0] addr,
  input  logic [WQE_LEN_W-1:0]  rem,
  output logic [MTU_LOG2:0]     seg_len,
  output logic                  last,
  output logic [WQE_ADDR_W-1:0] next_addr,
  output logic [WQE_LEN_W-1:0]  next_rem
);

  localparam logic [WQE_LEN_W:0] MTU_BYTES = mtu_bytes(MTU_LOG2);

  // A zero remainder also counts as last, so an empty WQE yields one len=0 segment.
  always_comb begin
    last      = ({1'b0, rem} <= MTU_BYTES);
    seg_len   = last ? rem[MTU_LOG2:0] : MTU_BYTES[MTU_LOG2:0];
    next_addr = addr + {{(WQE_ADDR_W-MTU_LOG2-1){1'b0}}, seg_len};
    next_rem  = rem - {{(WQE_LEN_W-MTU_LOG2-1){1'b0}}, seg_len};
  end

endmodule

// File: rtl/wqe_segmenter.sv
// Pops WQEs from the WQE cache and cuts each into MTU-sized segment descriptors
// with a valid/ready handshake toward the packet builder.
module wqe_segmenter
  import wqe_segmenter_pkg::*;
#(
  parameter int WQE_WIDTH    = 512,
  parameter int QP_PTR_WIDTH = 4,
  parameter int MTU_LOG2     = 12
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    i_wqe_cache_empty,
  output logic                    o_wqe_cache_rd,
  input  logic                    i_wqe_val,
  input  logic [WQE_WIDTH-1:0]    i_wqe,
  output logic                    o_seg_val,
  input  logic                    i_seg_rdy,
  output logic [QP_PTR_WIDTH-1:0] o_seg_qpn,
  output logic [63:0]             o_seg_wrid,
  output logic [63:0]             o_seg_addr,
  output logic [MTU_LOG2:0]       o_seg_len,
  output logic                    o_seg_first,
  output logic                    o_seg_last,
  output logic                    o_busy
);

  seg_state_e              state;
  logic                    arm_q;
  logic [QP_PTR_WIDTH-1:0] qpn_q;
  logic [WQE_WRID_W-1:0]   wrid_q;
  logic [WQE_ADDR_W-1:0]   addr_q;
  logic [WQE_LEN_W-1:0]    rem_q;
  logic                    first_q;

  logic [MTU_LOG2:0]       calc_len;
  logic                    calc_last;
  logic [WQE_ADDR_W-1:0]   calc_next_addr;
  logic [WQE_LEN_W-1:0]    calc_next_rem;
  logic                    unused_wqe_bits;

  assign unused_wqe_bits = ^i_wqe;

  seg_calc #(
    .MTU_LOG2 (MTU_LOG2)
  ) u_seg_calc (
    .addr      (addr_q),
    .rem       (rem_q),
    .seg_len   (calc_len),
    .last      (calc_last),
    .next_addr (calc_next_addr),
    .next_rem  (calc_next_rem)
  );

  // arm_q holds off the first pop until one full clock edge after reset release.
  assign o_wqe_cache_rd = arm_q && (state == SEG_IDLE) && !i_wqe_cache_empty;
  assign o_seg_val      = (state == SEG_SEG);
  assign o_busy         = (state != SEG_IDLE);
  assign o_seg_qpn      = qpn_q;
  assign o_seg_wrid     = wrid_q;
  assign o_seg_addr     = addr_q;
  assign o_seg_len      = calc_len;
  assign o_seg_first    = o_seg_val && first_q;
  assign o_seg_last     = o_seg_val && calc_last;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= SEG_IDLE;
      arm_q   <= 1'b0;
      qpn_q   <= '0;
      wrid_q  <= '0;
      addr_q  <= '0;
      rem_q   <= '0;
      first_q <= 1'b0;
    end else begin
      arm_q <= 1'b1;
      case (state)
        SEG_IDLE: begin
          if (o_wqe_cache_rd) state <= SEG_WAIT;
        end
        SEG_WAIT: begin
          if (i_wqe_val) begin
            qpn_q   <= i_wqe[WQE_QPID_LSB +: QP_PTR_WIDTH];
            wrid_q  <= i_wqe[WQE_WRID_LSB +: WQE_WRID_W];
            addr_q  <= i_wqe[WQE_ADDR_LSB +: WQE_ADDR_W];
            rem_q   <= i_wqe[WQE_LEN_LSB +: WQE_LEN_W];
            first_q <= 1'b1;
            state   <= SEG_SEG;
          end
        end
        SEG_SEG: begin
          if (i_seg_rdy) begin
            first_q <= 1'b0;
            if (calc_last) begin
              state <= SEG_IDLE;
            end else begin
              addr_q <= calc_next_addr;
              rem_q  <= calc_next_rem;
            end
          end
        end
        default: state <= SEG_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_wqe_segmenter.sv
// Bench for wqe_segmenter: a WQE cache responder, a descriptor model built from
// ceil(len/MTU) arithmetic, and directed plus randomized traffic.
module tb_wqe_segmenter;

  localparam int WQE_WIDTH = 512;
  localparam int QPW       = 4;
  localparam int MTU_LOG2  = 12;
  localparam longint unsigned MTU = 4096;

  typedef struct packed {
    logic [63:0]       addr;
    logic [MTU_LOG2:0] len;
    logic              first;
    logic              last;
    logic [QPW-1:0]    qpn;
    logic [63:0]       wrid;
  } desc_t;

  typedef struct {
    desc_t       d;
    int unsigned cyc;
  } log_t;

  typedef struct {
    logic [63:0]    addr;
    logic [31:0]    len;
    logic [QPW-1:0] qpn;
    logic [63:0]    wrid;
  } wqe_t;

  logic                 clk = 1'b0;
  logic                 rst_n = 1'b1;
  logic                 i_wqe_cache_empty;
  logic                 o_wqe_cache_rd;
  logic                 i_wqe_val;
  logic [WQE_WIDTH-1:0] i_wqe;
  logic                 o_seg_val;
  logic                 i_seg_rdy;
  logic [QPW-1:0]       o_seg_qpn;
  logic [63:0]          o_seg_wrid;
  logic [63:0]          o_seg_addr;
  logic [MTU_LOG2:0]    o_seg_len;
  logic                 o_seg_first;
  logic                 o_seg_last;
  logic                 o_busy;

  wqe_segmenter #(
    .WQE_WIDTH    (WQE_WIDTH),
    .QP_PTR_WIDTH (QPW),
    .MTU_LOG2     (MTU_LOG2)
  ) dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .i_wqe_cache_empty (i_wqe_cache_empty),
    .o_wqe_cache_rd    (o_wqe_cache_rd),
    .i_wqe_val         (i_wqe_val),
    .i_wqe             (i_wqe),
    .o_seg_val         (o_seg_val),
    .i_seg_rdy         (i_seg_rdy),
    .o_seg_qpn         (o_seg_qpn),
    .o_seg_wrid        (o_seg_wrid),
    .o_seg_addr        (o_seg_addr),
    .o_seg_len         (o_seg_len),
    .o_seg_first       (o_seg_first),
    .o_seg_last        (o_seg_last),
    .o_busy            (o_busy)
  );

  always #5 clk = ~clk;

  wqe_t        cache_q[$];
  desc_t       exp_q[$];
  log_t        xfer_log[$];
  int unsigned rd_log[$];
  int unsigned cyc = 0;
  int          n_cmp = 0;
  int          n_err = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] req);
    n_cmp++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, req);
    end
  endtask

  function automatic logic [WQE_WIDTH-1:0] build_wqe(input wqe_t w);
    logic [WQE_WIDTH-1:0] v;
    for (int i = 0; i < WQE_WIDTH/32; i++) v[i*32 +: 32] = $urandom;
    v[63:0]        = w.wrid;
    v[95:64]       = w.len;
    v[191:128]     = w.addr;
    v[328 +: QPW]  = w.qpn;
    return v;
  endfunction

  function automatic wqe_t mk_wqe(input logic [63:0] addr, input logic [31:0] len);
    wqe_t w;
    w.addr = addr;
    w.len  = len;
    w.qpn  = QPW'($urandom);
    w.wrid = {$urandom, $urandom};
    return w;
  endfunction

  // Reference: a WQE of len bytes becomes ceil(len/MTU) segments (one if len==0).
  function automatic void push_expected(input wqe_t w);
    longint unsigned n;
    desc_t d;
    n = (w.len == 0) ? 1 : (longint'(w.len) + MTU - 1) / MTU;
    for (longint unsigned i = 0; i < n; i++) begin
      d.addr  = w.addr + 64'(i * MTU);
      d.len   = (i == n - 1) ? (MTU_LOG2+1)'(longint'(w.len) - i * MTU) : (MTU_LOG2+1)'(MTU);
      d.first = (i == 0);
      d.last  = (i == n - 1);
      d.qpn   = w.qpn;
      d.wrid  = w.wrid;
      exp_q.push_back(d);
    end
  endfunction

  function automatic desc_t mk_desc(input logic [63:0] addr, input int len, input bit first,
                                    input bit last, input wqe_t w);
    desc_t d;
    d.addr = addr; d.len = (MTU_LOG2+1)'(len); d.first = first; d.last = last;
    d.qpn = w.qpn; d.wrid = w.wrid;
    return d;
  endfunction

  function automatic log_t get_log(input int i);
    log_t l;
    l.d = '0; l.cyc = 0;
    if (i < xfer_log.size()) l = xfer_log[i];
    return l;
  endfunction

  function automatic desc_t cur_desc();
    desc_t d;
    d.addr = o_seg_addr; d.len = o_seg_len; d.first = o_seg_first; d.last = o_seg_last;
    d.qpn = o_seg_qpn; d.wrid = o_seg_wrid;
    return d;
  endfunction

  // WQE cache: data with valid exactly one cycle after each pop, stray valid pulses otherwise.
  initial begin
    logic rd_s;
    wqe_t w;
    i_wqe_val = 1'b0;
    i_wqe = '0;
    i_wqe_cache_empty = 1'b1;
    forever begin
      @(negedge clk);
      rd_s = o_wqe_cache_rd;
      if (rd_s) rd_log.push_back(cyc);
      @(posedge clk);
      #1;
      if (rd_s && cache_q.size() > 0) begin
        w = cache_q.pop_front();
        i_wqe_val = 1'b1;
        i_wqe = build_wqe(w);
        push_expected(w);
      end else begin
        i_wqe_val = ($urandom_range(3) == 0);
        i_wqe = build_wqe(mk_wqe({$urandom, $urandom}, $urandom));
      end
      i_wqe_cache_empty = (cache_q.size() == 0);
    end
  end

  // Compare process: every accepted descriptor, every stall hold, every pop request.
  initial begin
    desc_t prev;
    desc_t cur;
    log_t  l;
    bit    stalled;
    stalled = 1'b0;
    prev = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        stalled = 1'b0;
      end else begin
        cur = cur_desc();
        if (o_wqe_cache_rd) check("rd_while_busy", 256'(o_busy), 256'(0));
        if (stalled) check("stall_hold", 256'({o_seg_val, cur}), 256'({1'b1, prev}));
        if (o_seg_val) begin
          if (i_seg_rdy) begin
            if (exp_q.size() == 0) begin
              n_cmp++;
              n_err++;
              $display("FAIL unexpected_desc: got %0h, expected no descriptor", cur);
            end else begin
              check("desc", 256'(cur), 256'(exp_q.pop_front()));
            end
            l.d = cur;
            l.cyc = cyc;
            xfer_log.push_back(l);
          end
          stalled = !i_seg_rdy;
          prev = cur;
        end else begin
          stalled = 1'b0;
        end
      end
    end
  end

  task automatic wait_xfers(input int target, input int budget, input string name);
    int t;
    t = 0;
    while (xfer_log.size() < target && t < budget) begin
      @(posedge clk);
      t++;
    end
    n_cmp++;
    if (xfer_log.size() < target) begin
      n_err++;
      $display("FAIL %s_timeout: got %0d transfers, expected %0d", name, xfer_log.size(), target);
    end
  endtask

  task automatic wait_idle(input int budget, input string name);
    int t;
    t = 0;
    while ((o_busy || exp_q.size() != 0 || cache_q.size() != 0) && t < budget) begin
      @(posedge clk);
      t++;
    end
    #1;
    n_cmp++;
    if (o_busy || exp_q.size() != 0 || cache_q.size() != 0) begin
      n_err++;
      $display("FAIL %s_idle_timeout: got busy=%0d pending=%0d, expected idle", name, o_busy, exp_q.size());
    end
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: got no completion, expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    wqe_t w, w2;
    int   b, rb, pushed;
    logic [63:0] raddr;
    logic [31:0] rlen;

    i_seg_rdy = 1'b0;
    #2 rst_n = 1'b0;

    // Reset state with a WQE waiting in the cache.
    w = mk_wqe(64'h1000, 32'd10000);
    cache_q.push_back(w);
    repeat (3) @(negedge clk);
    check("reset_outputs", 256'({o_wqe_cache_rd, o_seg_val, o_seg_qpn, o_seg_wrid, o_seg_addr,
                                 o_seg_len, o_seg_first, o_seg_last, o_busy}), 256'(0));
    @(posedge clk);
    #3 rst_n = 1'b1;
    #1 check("rd_before_first_edge", 256'(o_wqe_cache_rd), 256'(0));
    i_seg_rdy = 1'b1;

    // 10000 bytes at 0x1000: three back-to-back segments.
    b = xfer_log.size();
    wait_xfers(b + 3, 50, "len10000");
    check("len10000_seg0", 256'(get_log(b).d),     256'(mk_desc(64'h1000, 4096, 1, 0, w)));
    check("len10000_seg1", 256'(get_log(b + 1).d), 256'(mk_desc(64'h2000, 4096, 0, 0, w)));
    check("len10000_seg2", 256'(get_log(b + 2).d), 256'(mk_desc(64'h3000, 1808, 0, 1, w)));
    check("len10000_spacing", 256'(get_log(b + 2).cyc - get_log(b).cyc), 256'(2));
    wait_idle(50, "len10000");

    // Zero-length WQE.
    w = mk_wqe(64'hABCD_0000, 32'd0);
    b = xfer_log.size();
    cache_q.push_back(w);
    wait_xfers(b + 1, 50, "len0");
    check("len0_desc", 256'(get_log(b).d), 256'(mk_desc(64'hABCD_0000, 0, 1, 1, w)));
    @(negedge clk);
    check("len0_idle_next", 256'(o_busy), 256'(0));
    wait_idle(50, "len0");

    // 8192 bytes with a 5-cycle stall on the second segment.
    w = mk_wqe(64'h0004_0000, 32'd8192);
    b = xfer_log.size();
    cache_q.push_back(w);
    wait_xfers(b + 1, 50, "stall");
    #1 i_seg_rdy = 1'b0;
    repeat (5) @(posedge clk);
    #1 i_seg_rdy = 1'b1;
    wait_xfers(b + 2, 50, "stall");
    repeat (3) @(posedge clk);
    check("stall_count", 256'(xfer_log.size() - b), 256'(2));
    check("stall_seg1", 256'(get_log(b + 1).d), 256'(mk_desc(64'h0004_1000, 4096, 0, 1, w)));
    check("stall_gap", 256'(get_log(b + 1).cyc - get_log(b).cyc), 256'(6));
    wait_idle(50, "stall");

    // Address wrap past 2^64.
    w = mk_wqe(64'hFFFF_FFFF_FFFF_F000, 32'd8192);
    b = xfer_log.size();
    cache_q.push_back(w);
    wait_xfers(b + 2, 50, "wrap");
    check("wrap_seg0", 256'(get_log(b).d),     256'(mk_desc(64'hFFFF_FFFF_FFFF_F000, 4096, 1, 0, w)));
    check("wrap_seg1", 256'(get_log(b + 1).d), 256'(mk_desc(64'h0, 4096, 0, 1, w)));
    wait_idle(50, "wrap");

    // Two queued WQEs: second pop in the cycle after the first WQE's last transfer.
    w  = mk_wqe(64'h10_0000, 32'd5000);
    w2 = mk_wqe(64'h20_0000, 32'd300);
    b  = xfer_log.size();
    rb = rd_log.size();
    cache_q.push_back(w);
    cache_q.push_back(w2);
    wait_xfers(b + 3, 60, "two_wqe");
    check("two_wqe_rd_count", 256'(rd_log.size() - rb), 256'(2));
    if (rd_log.size() >= rb + 2)
      check("two_wqe_rd_timing", 256'(rd_log[rb + 1]), 256'(get_log(b + 1).cyc + 1));
    check("two_wqe_seg2", 256'(get_log(b + 2).d), 256'(mk_desc(64'h20_0000, 300, 1, 1, w2)));
    wait_idle(50, "two_wqe");

    // Reset in the middle of a 12288-byte WQE.
    w = mk_wqe(64'h0050_0000, 32'd12288);
    b = xfer_log.size();
    cache_q.push_back(w);
    wait_xfers(b + 1, 50, "midreset");
    #3 rst_n = 1'b0;
    #1 check("midreset_outputs", 256'({o_wqe_cache_rd, o_seg_val, o_seg_qpn, o_seg_wrid, o_seg_addr,
                                      o_seg_len, o_seg_first, o_seg_last, o_busy}), 256'(0));
    exp_q.delete();
    w2 = mk_wqe(64'h0060_0000, 32'd100);
    cache_q.push_back(w2);
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
    b = xfer_log.size();
    wait_xfers(b + 1, 50, "after_reset");
    check("after_reset_desc", 256'(get_log(b).d), 256'(mk_desc(64'h0060_0000, 100, 1, 1, w2)));
    wait_idle(50, "after_reset");
    check("after_reset_count", 256'(xfer_log.size() - b), 256'(1));

    // Randomized traffic with random back-pressure.
    pushed = 0;
    for (int c = 0; c < 20000 && (pushed < 40 || o_busy || exp_q.size() != 0 || cache_q.size() != 0); c++) begin
      @(posedge clk);
      #1;
      i_seg_rdy = ($urandom_range(3) != 0);
      if (pushed < 40 && $urandom_range(5) == 0) begin
        case ($urandom_range(4))
          0:       rlen = 32'd0;
          1:       rlen = 32'($urandom_range(1, 4096));
          2:       rlen = 32'(4096 * $urandom_range(1, 4));
          3:       rlen = 32'($urandom_range(4097, 20000));
          default: rlen = 32'(4096 * $urandom_range(1, 3) + 1);
        endcase
        raddr = ($urandom_range(3) == 0) ? {32'hFFFF_FFFF, 20'hFFFFF, 12'($urandom)} : {$urandom, $urandom};
        cache_q.push_back(mk_wqe(raddr, rlen));
        pushed++;
      end
    end
    i_seg_rdy = 1'b1;
    wait_idle(200, "random");
    check("random_drain", 256'(exp_q.size()), 256'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/wqe_segmenter.md
WQE_SEGMENTER -- requirements
Module: wqe_segmenter

Interface
REQ-001 Parameter WQE_WIDTH, default 512, width of one WQE.
REQ-002 Parameter QP_PTR_WIDTH, default 4, QP number width.
REQ-003 Parameter MTU_LOG2, default 12, log2 of segment payload size in bytes (MTU = 4096).
REQ-004 clk  in  1  clock; all logic is rising-edge.
REQ-005 rst_n  in  1  reset; asynchronous, active-low.
REQ-006 i_wqe_cache_empty  in  1  WQE cache has no entries.
REQ-007 o_wqe_cache_rd  out  1  pop request to the WQE cache.
REQ-008 i_wqe_val  in  1  popped WQE valid; arrives exactly 1 cycle after o_wqe_cache_rd.
REQ-009 i_wqe  in  WQE_WIDTH  popped WQE.
REQ-010 o_seg_val  out  1  segment descriptor valid.
REQ-011 i_seg_rdy  in  1  downstream accepts the descriptor.
REQ-012 o_seg_qpn  out  QP_PTR_WIDTH  QP number, from i_wqe[328+QP_PTR_WIDTH-1:328].
REQ-013 o_seg_wrid  out  64  work request ID, from i_wqe[63:0].
REQ-014 o_seg_addr  out  64  segment start address.
REQ-015 o_seg_len  out  MTU_LOG2+1  segment byte count.
REQ-016 o_seg_first / o_seg_last  out  1 each  first/last segment of the WQE.
REQ-017 o_busy  out  1  FSM is not in IDLE.

Function
REQ-018 WQE fields: byte length = i_wqe[95:64] (32-bit unsigned); base address = i_wqe[191:128].
REQ-019 The FSM SHALL have states IDLE, WAIT and SEG.
REQ-020 In IDLE, o_wqe_cache_rd SHALL be 1 for one cycle iff i_wqe_cache_empty=0; the FSM then goes to WAIT.
REQ-021 At most one read SHALL be outstanding; o_wqe_cache_rd SHALL be 0 in WAIT and SEG.
REQ-022 In WAIT, on i_wqe_val=1 the block SHALL latch qpn, wrid, address and length, then go to SEG.
REQ-023 In WAIT, i_wqe_val=0 SHALL keep the FSM in WAIT (no timeout).
REQ-024 In SEG, o_seg_val SHALL be 1. A descriptor transfers when o_seg_val=1 and i_seg_rdy=1.
REQ-025 While o_seg_val=1 and i_seg_rdy=0, all o_seg_* outputs SHALL hold stable.
REQ-026 Segment length SHALL be min(remaining, 2^MTU_LOG2). The WQE is cut into ceil(len/MTU) segments.
REQ-027 After each transfer, the address SHALL advance by the segment length (modulo 2^64) and remaining SHALL decrease by the segment length.
REQ-028 o_seg_first SHALL be 1 only on the first segment; o_seg_last SHALL be 1 only when remaining <= MTU.
REQ-029 A zero-length WQE SHALL emit exactly one descriptor with len=0, first=1 and last=1.
REQ-030 A transfer with last=1 SHALL return the FSM to IDLE.
REQ-031 Throughput: one segment per cycle while i_seg_rdy=1. Minimum spacing between WQEs is 2 cycles (IDLE, WAIT).
REQ-032 An i_wqe_val pulse outside WAIT SHALL be ignored.

Reset
REQ-033 Asserting rst_n SHALL, asynchronously and at any point (including mid-WQE): force IDLE, drive o_wqe_cache_rd, o_seg_val, o_seg_first, o_seg_last and o_busy to 0, clear all other outputs and latched fields to 0, and discard any in-flight WQE.
REQ-034 After rst_n deasserts, the first read SHALL occur no earlier than the first rising edge of clk.

Structure
REQ-035 WQE field bit positions (WRID 63:0, LEN 95:64, ADDR 191:128, QPID LSB 328) and FSM state encodings SHALL live in a shared package, also used by the WQE cache.
REQ-036 A single sub-module, seg_calc, SHALL compute the segment length, last flag and next address/remaining combinationally. Everything else is flat.

Verification
REQ-037 len=10000, addr=0x1000, rdy=1 -> 3 segments: (0x1000, 4096, first), (0x2000, 4096), (0x3000, 1808, last), on consecutive cycles.
REQ-038 len=0 -> one descriptor with len=0, first=1, last=1; FSM back in IDLE the next cycle.
REQ-039 len=8192, i_seg_rdy low for 5 cycles on segment 2 -> outputs held; exactly 2 descriptors; the second has last=1.
REQ-040 addr=0xFFFF_FFFF_FFFF_F000, len=8192 -> segment 2 addr=0x0 (wrap).
REQ-041 Two queued WQEs, cache non-empty -> the second read is issued in the cycle after the first WQE's last transfer; never 2 outstanding reads.
REQ-042 rst_n asserted mid-segment of a len=12288 WQE -> all outputs 0 immediately; after release, a fresh read is issued with no residual segments.
